// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, programmable latency.
// Optional response jitter is enabled with `define MEM_RESP_JITTER_EN.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          acc_wen;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_wmask;
  logic [31:0]   off;
  logic          in_rng;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic          mem_we;
  logic          enter_resp;
  logic [4:0]    wait_tot;
  logic          unused_ok;

`ifdef MEM_RESP_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       lfsr_fb;

  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign wait_tot = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};

  // Jitter LFSR, stepped once per accepted request.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign wait_tot = 5'(LATENCY);
`endif

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // From IDLE (zero latency) the live request is used, else the latched one.
  always_comb begin
    acc_wen   = wen_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wmask = wmask_q;
    if (state_q == S_IDLE) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end
  end

  // Address decode and byte-merged write word.
  always_comb begin
    off     = acc_addr - BASE_ADDR;
    in_rng  = ({1'b0, off} < SPAN);
    idx     = off[AW+1:2];
    rd_word = mem[idx];
    wr_word = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (acc_wmask[i]) wr_word[8*i +: 8] = acc_wdata[8*i +: 8];
    end
  end

  assign unused_ok = ^off[1:0];

  // Next-state, counter, request latch and response data.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
`ifdef MEM_RESP_JITTER_EN
    lfsr_d     = lfsr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
`ifdef MEM_RESP_JITTER_EN
          lfsr_d  = {lfsr_q[6:0], lfsr_fb};
`endif
          if (wait_tot == 5'd0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = wait_tot - 5'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 5'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = ~in_rng;
      rdata_d = (in_rng && !acc_wen) ? rd_word : 32'h0;
    end
  end

  assign mem_we = enter_resp && in_rng && acc_wen && !reset;

  // State and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Backing array; contents survive reset, writes are dropped under reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wr_word;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table, corner sequences, random vs model.
// Default build (fixed latency LATENCY=1).
module tb_mem_responder;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(
    .BASE_ADDR(32'h8000_0000),
    .DEPTH    (1024),
    .LATENCY  (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen  (req_wen),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction; lat counts cycles from the accept edge
  // until rsp_valid is seen (1 = visible right after the accept edge).
  task automatic do_req(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input int hold, output logic [31:0] rdata,
                        output logic err, output int lat);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    tick();
    req_valid = 1'b0;
    req_wen   = ~wen;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wmask = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!rsp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles", lat);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_rdata", rsp_rdata, rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] mdl [8];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd0;
    logic        er;
    int          lat;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0010, 32'h0000_00AA, 4'h1, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0};
    vecs[4]  = '{1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1};
    vecs[5]  = '{1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1'b1};
    vecs[6]  = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0};
    vecs[8]  = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0};
    vecs[10] = '{1'b1, 32'h8000_0FFC, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 32'h8000_0FFF, 32'h0, 4'h0, 32'h1122_3344, 1'b0};
    vecs[12] = '{1'b1, 32'h8000_0013, 32'hAABB_CCDD, 4'hA, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hAAAD_CCAA, 1'b0};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_wmask = 4'h0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      tick();
    end

    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
             i % 3, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT + 1));
    end

    // Backpressure: response held 10 cycles, new request ignored.
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 32'h8000_0010;
    tick();
    req_valid = 1'b0;
    repeat (LAT) tick();
    chk("bp_valid_up", 32'(rsp_valid), 32'd1);
    rd0       = rsp_rdata;
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0010;
    req_wdata = 32'h5555_5555;
    req_wmask = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hAAAD_CCAA);
      chk("bp_rdata_stable", rsp_rdata, rd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    chk("bp_no_write", rd, 32'hAAAD_CCAA);

    // Reset during WAIT drops the pending write.
    do_req(1'b1, 32'h8000_0020, 32'h0, 4'hF, 0, rd, er, lat);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'h1234_5678;
    req_wmask = 4'hF;
    tick();
    req_valid = 1'b0;
    chk("wait_not_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_rdata", rsp_rdata, 32'h0);
    repeat (3) tick();
    chk("abort_still_idle", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er, lat);
    chk("abort_readback", rd, 32'h0);
    chk("abort_readback_err", 32'(er), 32'd0);

    // Random traffic against a byte-level model of 8 words.
    for (int k = 0; k < 8; k++) begin
      mdl[k] = $urandom;
      do_req(1'b1, 32'h8000_0100 + 32'(4 * k), mdl[k], 4'hF, 0,
             rd, er, lat);
    end
    for (int t = 0; t < 150; t++) begin
      logic        w, oob;
      logic [31:0] a, d, exp_d;
      logic [3:0]  m;
      int          k;
      k     = $urandom_range(0, 7);
      w     = 1'($urandom);
      d     = $urandom;
      m     = 4'($urandom);
      oob   = ($urandom_range(0, 9) < 2);
      exp_d = 32'h0;
      if (oob) begin
        if ($urandom_range(0, 1) == 1)
          a = 32'h8000_1000 + ($urandom & 32'h07FF_FFFF);
        else
          a = 32'h7FFF_FFFC - ($urandom & 32'h0000_FFFF);
      end else begin
        a = 32'h8000_0100 + 32'(4 * k) + 32'($urandom_range(0, 3));
        if (w) begin
          for (int b = 0; b < 4; b++)
            if (m[b]) mdl[k][8*b +: 8] = d[8*b +: 8];
        end else begin
          exp_d = mdl[k];
        end
      end
      do_req(w, a, d, m, $urandom_range(0, 3), rd, er, lat);
      chk($sformatf("rnd%0d_rdata", t), rd, exp_d);
      chk($sformatf("rnd%0d_err", t), 32'(er), 32'(oob));
      chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'(LAT + 1));
    end
    for (int k = 0; k < 8; k++) begin
      do_req(1'b0, 32'h8000_0100 + 32'(4 * k), 32'h0, 4'h0, 0,
             rd, er, lat);
      chk($sformatf("final%0d", k), rd, mdl[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
